// File: rtl/periph_bus_buffer.sv
// ---------------------------------------------------------------------------
// periph_bus_buffer
//
// Request/response buffer for the cluster peripheral bus. Upstream requests
// (req/gnt handshake) are captured into a DEPTH-entry FIFO and replayed
// downstream in order, so the upstream grant never depends combinationally
// on the downstream grant. Responses (r_valid channel) either pass straight
// through or go through a single register stage, selected by RESP_REG.
//
// Parameters
//   ADDR_WIDTH  address width
//   DATA_WIDTH  data width, multiple of 8 (byte enables = DATA_WIDTH/8)
//   ID_WIDTH    transaction ID width
//   DEPTH       request FIFO entries (>= 1, any value)
//   RESP_REG    1 = registered response path, 0 = combinational pass-through
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   s_req_i .. s_id_i, s_gnt_o    upstream request channel
//   s_r_valid_o .. s_r_rdata_o    upstream response channel
//   m_req_o .. m_id_o, m_gnt_i    downstream request channel
//   m_r_valid_i .. m_r_rdata_i    downstream response channel
//   fill_o                        current FIFO occupancy (registered)
// ---------------------------------------------------------------------------
module periph_bus_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 9,
  parameter int DEPTH      = 2,
  parameter bit RESP_REG   = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // upstream request
  input  logic                      s_req_i,
  input  logic [ADDR_WIDTH-1:0]     s_add_i,
  input  logic                      s_wen_i,
  input  logic [DATA_WIDTH-1:0]     s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   s_be_i,
  input  logic [ID_WIDTH-1:0]       s_id_i,
  output logic                      s_gnt_o,
  // upstream response
  output logic                      s_r_valid_o,
  output logic                      s_r_opc_o,
  output logic [ID_WIDTH-1:0]       s_r_id_o,
  output logic [DATA_WIDTH-1:0]     s_r_rdata_o,
  // downstream request
  output logic                      m_req_o,
  output logic [ADDR_WIDTH-1:0]     m_add_o,
  output logic                      m_wen_o,
  output logic [DATA_WIDTH-1:0]     m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   m_be_o,
  output logic [ID_WIDTH-1:0]       m_id_o,
  input  logic                      m_gnt_i,
  // downstream response
  input  logic                      m_r_valid_i,
  input  logic                      m_r_opc_i,
  input  logic [ID_WIDTH-1:0]       m_r_id_i,
  input  logic [DATA_WIDTH-1:0]     m_r_rdata_i,
  // occupancy
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int FILL_W   = $clog2(DEPTH + 1);
  // A single-entry FIFO still needs a 1-bit pointer to keep the types legal;
  // it simply never leaves 0.
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W  = ADDR_WIDTH + 1 + DATA_WIDTH + BE_WIDTH + ID_WIDTH;

  // Elaboration-time sanity checks on the generics.
  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "periph_bus_buffer: DEPTH must be >= 1");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $fatal(1, "periph_bus_buffer: DATA_WIDTH must be a multiple of 8");
  end

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] s_entry;
  logic [ENTRY_W-1:0] head_entry;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;

  logic               push;
  logic               pop;

  // Pointers count 0..DEPTH-1 and wrap explicitly, so non-power-of-2
  // depths work without wasting entries.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Grant depends only on registered occupancy and reset: a full FIFO
  // refuses a push even if a pop happens in the same cycle, which keeps
  // m_gnt_i out of the upstream grant path.
  assign s_gnt_o = (fill_q != FILL_W'(DEPTH)) && !rst_i;
  assign m_req_o = (fill_q != '0);
  assign push    = s_req_i && s_gnt_o;
  assign pop     = m_req_o && m_gnt_i;
  assign fill_o  = fill_q;

  assign s_entry    = {s_add_i, s_wen_i, s_wdata_i, s_be_i, s_id_i};
  assign head_entry = mem_q[rd_ptr_q];
  assign {m_add_o, m_wen_o, m_wdata_o, m_be_o, m_id_o} = head_entry;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage has no reset: contents are only observable while m_req_o=1,
  // and every such entry has been written by a push.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_entry;
    end
  end

  if (RESP_REG) begin : g_resp_reg
    logic                  r_valid_q;
    logic                  r_opc_q;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [DATA_WIDTH-1:0] r_rdata_q;

    // Valid follows the input every cycle (single-cycle pulses stay single
    // cycle); the payload only loads on a valid beat and holds otherwise.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_valid_q <= 1'b0;
        r_opc_q   <= 1'b0;
        r_id_q    <= '0;
        r_rdata_q <= '0;
      end else begin
        r_valid_q <= m_r_valid_i;
        if (m_r_valid_i) begin
          r_opc_q   <= m_r_opc_i;
          r_id_q    <= m_r_id_i;
          r_rdata_q <= m_r_rdata_i;
        end
      end
    end

    assign s_r_valid_o = r_valid_q;
    assign s_r_opc_o   = r_opc_q;
    assign s_r_id_o    = r_id_q;
    assign s_r_rdata_o = r_rdata_q;
  end else begin : g_resp_comb
    assign s_r_valid_o = m_r_valid_i;
    assign s_r_opc_o   = m_r_opc_i;
    assign s_r_id_o    = m_r_id_i;
    assign s_r_rdata_o = m_r_rdata_i;
  end

endmodule

// File: tb/tb_periph_bus_buffer.sv
// ---------------------------------------------------------------------------
// tb_periph_bus_buffer
//
// Directed testbench for periph_bus_buffer. Two instances share clock and
// reset: dut (DEPTH=2, registered response) and dut3 (DEPTH=3, combinational
// response). Inputs are driven 1 ns after the rising edge and outputs are
// sampled 1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_periph_bus_buffer;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [8:0]  id;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A: DEPTH=2, RESP_REG=1 ----------------
  logic        s_req = 1'b0, s_wen = 1'b0;
  logic [31:0] s_add = '0, s_wdata = '0;
  logic [3:0]  s_be = '0;
  logic [8:0]  s_id = '0;
  logic        s_gnt;
  logic        s_r_valid, s_r_opc;
  logic [8:0]  s_r_id;
  logic [31:0] s_r_rdata;
  logic        m_req, m_wen;
  logic [31:0] m_add, m_wdata;
  logic [3:0]  m_be;
  logic [8:0]  m_id;
  logic        m_gnt = 1'b0;
  logic        m_r_valid = 1'b0, m_r_opc = 1'b0;
  logic [8:0]  m_r_id = '0;
  logic [31:0] m_r_rdata = '0;
  logic [1:0]  fill;

  periph_bus_buffer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(9), .DEPTH(2), .RESP_REG(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_req_i(s_req), .s_add_i(s_add), .s_wen_i(s_wen), .s_wdata_i(s_wdata),
    .s_be_i(s_be), .s_id_i(s_id), .s_gnt_o(s_gnt),
    .s_r_valid_o(s_r_valid), .s_r_opc_o(s_r_opc), .s_r_id_o(s_r_id),
    .s_r_rdata_o(s_r_rdata),
    .m_req_o(m_req), .m_add_o(m_add), .m_wen_o(m_wen), .m_wdata_o(m_wdata),
    .m_be_o(m_be), .m_id_o(m_id), .m_gnt_i(m_gnt),
    .m_r_valid_i(m_r_valid), .m_r_opc_i(m_r_opc), .m_r_id_i(m_r_id),
    .m_r_rdata_i(m_r_rdata),
    .fill_o(fill)
  );

  // ---------------- instance B: DEPTH=3, RESP_REG=0 ----------------
  logic        s_req3 = 1'b0, s_wen3 = 1'b0;
  logic [31:0] s_add3 = '0, s_wdata3 = '0;
  logic [3:0]  s_be3 = '0;
  logic [8:0]  s_id3 = '0;
  logic        s_gnt3;
  logic        s_r_valid3, s_r_opc3;
  logic [8:0]  s_r_id3;
  logic [31:0] s_r_rdata3;
  logic        m_req3, m_wen3;
  logic [31:0] m_add3, m_wdata3;
  logic [3:0]  m_be3;
  logic [8:0]  m_id3;
  logic        m_gnt3 = 1'b0;
  logic        m_r_valid3 = 1'b0, m_r_opc3 = 1'b0;
  logic [8:0]  m_r_id3 = '0;
  logic [31:0] m_r_rdata3 = '0;
  logic [1:0]  fill3;

  periph_bus_buffer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(9), .DEPTH(3), .RESP_REG(1'b0)
  ) dut3 (
    .clk_i(clk), .rst_i(rst),
    .s_req_i(s_req3), .s_add_i(s_add3), .s_wen_i(s_wen3), .s_wdata_i(s_wdata3),
    .s_be_i(s_be3), .s_id_i(s_id3), .s_gnt_o(s_gnt3),
    .s_r_valid_o(s_r_valid3), .s_r_opc_o(s_r_opc3), .s_r_id_o(s_r_id3),
    .s_r_rdata_o(s_r_rdata3),
    .m_req_o(m_req3), .m_add_o(m_add3), .m_wen_o(m_wen3), .m_wdata_o(m_wdata3),
    .m_be_o(m_be3), .m_id_o(m_id3), .m_gnt_i(m_gnt3),
    .m_r_valid_i(m_r_valid3), .m_r_opc_i(m_r_opc3), .m_r_id_i(m_r_id3),
    .m_r_rdata_i(m_r_rdata3),
    .fill_o(fill3)
  );

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_checks++; if (s_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_gnt: got %b expected 0", s_gnt); end
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_m_req: got %b expected 0", m_req); end
    n_checks++; if (fill !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_fill: got %0d expected 0", fill); end
    n_checks++; if (s_r_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_r_valid: got %b expected 0", s_r_valid); end
    n_checks++; if (s_r_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_r_rdata: got %h expected 0", s_r_rdata); end
    n_checks++; if (s_r_id !== 9'h0) begin n_fail++; $display("[TB] FAIL rst_r_id: got %h expected 0", s_r_id); end
    n_checks++; if (s_gnt3 !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_gnt3: got %b expected 0", s_gnt3); end
    rst = 1'b0;
    #1;
    n_checks++; if (s_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_gnt: got %b expected 1", s_gnt); end
    n_checks++; if (s_gnt3 !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_gnt3: got %b expected 1", s_gnt3); end
  endtask

  task automatic test_single_write();
    m_gnt   = 1'b0;
    s_req   = 1'b1;
    s_add   = 32'h1000_0040;
    s_wdata = 32'hDEAD_BEEF;
    s_be    = 4'hF;
    s_id    = 9'd3;
    s_wen   = 1'b0;
    #1;
    n_checks++; if (s_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL single_gnt: got %b expected 1", s_gnt); end
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("[TB] FAIL single_no_bypass: got %b expected 0", m_req); end
    tick();
    s_req = 1'b0;
    #1;
    n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("[TB] FAIL single_m_req: got %b expected 1", m_req); end
    n_checks++; if (m_add !== 32'h1000_0040) begin n_fail++; $display("[TB] FAIL single_add: got %h expected 10000040", m_add); end
    n_checks++; if (m_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL single_wdata: got %h expected deadbeef", m_wdata); end
    n_checks++; if (m_be !== 4'hF) begin n_fail++; $display("[TB] FAIL single_be: got %h expected f", m_be); end
    n_checks++; if (m_id !== 9'd3) begin n_fail++; $display("[TB] FAIL single_id: got %0d expected 3", m_id); end
    n_checks++; if (m_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL single_wen: got %b expected 0", m_wen); end
    n_checks++; if (fill !== 2'd1) begin n_fail++; $display("[TB] FAIL single_fill1: got %0d expected 1", fill); end
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    #1;
    n_checks++; if (fill !== 2'd0) begin n_fail++; $display("[TB] FAIL single_fill0: got %0d expected 0", fill); end
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("[TB] FAIL single_m_req0: got %b expected 0", m_req); end
  endtask

  task automatic test_backpressure();
    m_gnt = 1'b0;
    s_req = 1'b1; s_wen = 1'b1; s_be = 4'h3;
    for (int k = 1; k <= 2; k++) begin
      s_id = 9'(k); s_add = 32'h3000_0000 + 32'(k); s_wdata = 32'h1111_0000 + 32'(k);
      #1;
      n_checks++; if (s_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_gnt_%0d: got %b expected 1", k, s_gnt); end
      tick();
    end
    s_id = 9'd3; s_add = 32'h3000_0003; s_wdata = 32'h1111_0003;
    #1;
    n_checks++; if (s_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_full_gnt: got %b expected 0", s_gnt); end
    n_checks++; if (fill !== 2'd2) begin n_fail++; $display("[TB] FAIL bp_fill2: got %0d expected 2", fill); end
    tick();
    #1;
    n_checks++; if (m_id !== 9'd1) begin n_fail++; $display("[TB] FAIL bp_stable_id: got %0d expected 1", m_id); end
    n_checks++; if (s_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_still_full: got %b expected 0", s_gnt); end
    // Releasing downstream grant must not reopen the upstream grant this cycle.
    m_gnt = 1'b1;
    #1;
    n_checks++; if (s_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_no_comb_path: got %b expected 0", s_gnt); end
    tick();
    #1;
    n_checks++; if (s_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_gnt_after_pop: got %b expected 1", s_gnt); end
    n_checks++; if (m_id !== 9'd2) begin n_fail++; $display("[TB] FAIL bp_order2: got %0d expected 2", m_id); end
    n_checks++; if (fill !== 2'd1) begin n_fail++; $display("[TB] FAIL bp_fill1: got %0d expected 1", fill); end
    tick();
    s_req = 1'b0;
    #1;
    n_checks++; if (m_id !== 9'd3) begin n_fail++; $display("[TB] FAIL bp_order3: got %0d expected 3", m_id); end
    n_checks++; if (m_add !== 32'h3000_0003) begin n_fail++; $display("[TB] FAIL bp_add3: got %h expected 30000003", m_add); end
    n_checks++; if (fill !== 2'd1) begin n_fail++; $display("[TB] FAIL bp_fill_pushpop: got %0d expected 1", fill); end
    tick();
    m_gnt = 1'b0;
    #1;
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drained: got %b expected 0", m_req); end
  endtask

  task automatic test_streaming();
    m_gnt = 1'b1;
    s_req = 1'b1; s_wen = 1'b0; s_be = 4'hC;
    for (int k = 0; k < 8; k++) begin
      s_id    = 9'(10 + k);
      s_add   = 32'h2000_0000 + 32'(k * 16);
      s_wdata = 32'hA5A5_0000 | 32'(k);
      #1;
      n_checks++; if (s_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_gnt_%0d: got %b expected 1", k, s_gnt); end
      if (k > 0) begin
        n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_req_%0d: got %b expected 1", k, m_req); end
        n_checks++; if (m_id !== 9'(9 + k)) begin n_fail++; $display("[TB] FAIL stream_id_%0d: got %0d expected %0d", k, m_id, 9 + k); end
        n_checks++; if (m_add !== 32'h2000_0000 + 32'((k - 1) * 16)) begin n_fail++; $display("[TB] FAIL stream_add_%0d: got %h expected %h", k, m_add, 32'h2000_0000 + 32'((k - 1) * 16)); end
        n_checks++; if (fill !== 2'd1) begin n_fail++; $display("[TB] FAIL stream_fill_%0d: got %0d expected 1", k, fill); end
      end
      tick();
    end
    s_req = 1'b0;
    #1;
    n_checks++; if (m_id !== 9'd17) begin n_fail++; $display("[TB] FAIL stream_last_id: got %0d expected 17", m_id); end
    n_checks++; if (m_wdata !== 32'hA5A5_0007) begin n_fail++; $display("[TB] FAIL stream_last_wdata: got %h expected a5a50007", m_wdata); end
    tick();
    m_gnt = 1'b0;
    #1;
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_empty: got %b expected 0", m_req); end
    n_checks++; if (fill !== 2'd0) begin n_fail++; $display("[TB] FAIL stream_fill0: got %0d expected 0", fill); end
  endtask

  task automatic test_response();
    m_r_valid = 1'b1; m_r_id = 9'd5; m_r_rdata = 32'hCAFE_0001; m_r_opc = 1'b1;
    #1;
    n_checks++; if (s_r_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL resp_reg_early: got %b expected 0", s_r_valid); end
    tick();
    m_r_valid = 1'b0; m_r_id = 9'd7; m_r_rdata = 32'h1234_5678; m_r_opc = 1'b0;
    #1;
    n_checks++; if (s_r_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL resp_reg_valid: got %b expected 1", s_r_valid); end
    n_checks++; if (s_r_id !== 9'd5) begin n_fail++; $display("[TB] FAIL resp_reg_id: got %0d expected 5", s_r_id); end
    n_checks++; if (s_r_rdata !== 32'hCAFE_0001) begin n_fail++; $display("[TB] FAIL resp_reg_rdata: got %h expected cafe0001", s_r_rdata); end
    n_checks++; if (s_r_opc !== 1'b1) begin n_fail++; $display("[TB] FAIL resp_reg_opc: got %b expected 1", s_r_opc); end
    tick();
    #1;
    n_checks++; if (s_r_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL resp_reg_pulse: got %b expected 0", s_r_valid); end
    n_checks++; if (s_r_rdata !== 32'hCAFE_0001) begin n_fail++; $display("[TB] FAIL resp_reg_hold: got %h expected cafe0001", s_r_rdata); end
    n_checks++; if (s_r_id !== 9'd5) begin n_fail++; $display("[TB] FAIL resp_reg_hold_id: got %0d expected 5", s_r_id); end
    m_r_id = 9'd0; m_r_rdata = 32'h0;
    // Combinational instance: same-cycle pass-through.
    m_r_valid3 = 1'b1; m_r_id3 = 9'd5; m_r_rdata3 = 32'hCAFE_0001; m_r_opc3 = 1'b1;
    #1;
    n_checks++; if (s_r_valid3 !== 1'b1) begin n_fail++; $display("[TB] FAIL resp_comb_valid: got %b expected 1", s_r_valid3); end
    n_checks++; if (s_r_id3 !== 9'd5) begin n_fail++; $display("[TB] FAIL resp_comb_id: got %0d expected 5", s_r_id3); end
    n_checks++; if (s_r_rdata3 !== 32'hCAFE_0001) begin n_fail++; $display("[TB] FAIL resp_comb_rdata: got %h expected cafe0001", s_r_rdata3); end
    n_checks++; if (s_r_opc3 !== 1'b1) begin n_fail++; $display("[TB] FAIL resp_comb_opc: got %b expected 1", s_r_opc3); end
    tick();
    m_r_valid3 = 1'b0; m_r_opc3 = 1'b0; m_r_id3 = '0; m_r_rdata3 = '0;
    #1;
    n_checks++; if (s_r_valid3 !== 1'b0) begin n_fail++; $display("[TB] FAIL resp_comb_drop: got %b expected 0", s_r_valid3); end
  endtask

  task automatic test_random_depth3();
    req_t sb[$];
    req_t cur;
    req_t exp_head;
    int   pops = 0;
    int   cycles = 0;
    int   exp_fill;
    logic do_push, do_pop;
    while (pops < 1000 && cycles < 20000) begin
      cur.add   = $urandom;
      cur.wen   = 1'($urandom_range(0, 1));
      cur.wdata = $urandom;
      cur.be    = 4'($urandom_range(0, 15));
      cur.id    = 9'($urandom_range(0, 511));
      s_req3 = ($urandom_range(0, 9) < 7);
      m_gnt3 = ($urandom_range(0, 9) < 6);
      {s_add3, s_wen3, s_wdata3, s_be3, s_id3} = cur;
      #1;
      exp_fill = sb.size();
      n_checks++; if (s_gnt3 !== (exp_fill != 3)) begin n_fail++; $display("[TB] FAIL rnd_gnt cyc %0d: got %b expected %b", cycles, s_gnt3, exp_fill != 3); end
      n_checks++; if (m_req3 !== (exp_fill != 0)) begin n_fail++; $display("[TB] FAIL rnd_req cyc %0d: got %b expected %b", cycles, m_req3, exp_fill != 0); end
      n_checks++; if (fill3 !== 2'(exp_fill)) begin n_fail++; $display("[TB] FAIL rnd_fill cyc %0d: got %0d expected %0d", cycles, fill3, exp_fill); end
      n_checks++; if (fill3 > 2'd3) begin n_fail++; $display("[TB] FAIL rnd_fill_bound cyc %0d: got %0d expected <=3", cycles, fill3); end
      if (exp_fill != 0) begin
        exp_head = sb[0];
        n_checks++; if ({m_add3, m_wen3, m_wdata3, m_be3, m_id3} !== exp_head) begin n_fail++; $display("[TB] FAIL rnd_head cyc %0d: got %h expected %h", cycles, {m_add3, m_wen3, m_wdata3, m_be3, m_id3}, exp_head); end
      end
      do_push = s_req3 && (exp_fill != 3);
      do_pop  = m_gnt3 && (exp_fill != 0);
      if (do_pop) begin
        void'(sb.pop_front());
        pops++;
      end
      if (do_push) sb.push_back(cur);
      tick();
      cycles++;
    end
    s_req3 = 1'b0;
    m_gnt3 = 1'b0;
    n_checks++; if (pops < 1000) begin n_fail++; $display("[TB] FAIL rnd_timeout: got %0d pops expected 1000", pops); end
  endtask

  task automatic test_reset_mid();
    m_gnt = 1'b0;
    s_req = 1'b1; s_id = 9'd40; s_add = 32'h4000_0000; s_wdata = 32'h5555_5555; s_be = 4'h1;
    tick();
    s_id = 9'd41;
    tick();
    s_req = 1'b0;
    m_r_valid = 1'b1; m_r_id = 9'd9; m_r_rdata = 32'hBEEF_0009;
    #1;
    n_checks++; if (fill !== 2'd2) begin n_fail++; $display("[TB] FAIL mid_pre_fill: got %0d expected 2", fill); end
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (s_r_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pre_valid: got %b expected 1", s_r_valid); end
    n_checks++; if (s_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_gnt_in_rst: got %b expected 0", s_gnt); end
    tick();
    #1;
    n_checks++; if (fill !== 2'd0) begin n_fail++; $display("[TB] FAIL mid_fill: got %0d expected 0", fill); end
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_m_req: got %b expected 0", m_req); end
    n_checks++; if (s_r_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_r_valid: got %b expected 0", s_r_valid); end
    n_checks++; if (s_r_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_r_rdata: got %h expected 0", s_r_rdata); end
    n_checks++; if (s_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_gnt_held: got %b expected 0", s_gnt); end
    rst = 1'b0;
    m_r_valid = 1'b0;
    #1;
    n_checks++; if (s_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_gnt_release: got %b expected 1", s_gnt); end
    tick();
    #1;
    n_checks++; if (s_r_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_post_valid: got %b expected 0", s_r_valid); end
  endtask

  initial begin
    $display("[TB] periph_bus_buffer directed test");
    test_reset();
    test_single_write();
    test_backpressure();
    test_streaming();
    test_response();
    test_random_depth3();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
